// File: rtl/ifetch_pkg.sv
// ifetch_pkg -- shared types and defaults for the instruction fetch unit.
//   fetch_state_e : fetch FSM states (IDLE, REQ, DRAIN)
//   fetch_entry_t : one buffer entry, {pc, instr}
//   align_word()  : clears the byte-offset bits of an address
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          DEPTH_DEFAULT    = 4;

    // Every bit of the address takes part, so no input bits are left dangling.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo -- instruction buffer holding {pc, instr} entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear, wins over push and pop
//   push       : write push_data at the tail
//   pop        : drop the head (ignored when empty)
//   head       : head entry, all zeros when empty
//   count      : number of valid entries (0..DEPTH)
//   not_empty  : count != 0
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     not_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pop_ok_s;
    logic               push_ok_s;

    // Next-state for storage, pointers and occupancy; flush has top priority.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        pop_ok_s  = pop && (cnt_q != {CNT_W{1'b0}});
        // A push into a full buffer is only accepted when a pop frees a slot.
        push_ok_s = push && ((cnt_q != FULL_CNT) || pop_ok_s);
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign not_empty = (cnt_q != {CNT_W{1'b0}});
    assign count     = cnt_q;
    // Stale slots never leak out: the head reads as zero whenever empty.
    assign head      = not_empty ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit -- instruction fetch: issues word reads, buffers the results
// and presents them in order to the core; handles redirects (flush+refetch).
//   clk, rst_n         : clock, asynchronous active-low reset
//   mem_req/mem_addr   : read request and word-aligned address (registered)
//   mem_ack/mem_rdata  : request accepted, data returned in the same cycle
//   redirect/redirect_pc : flush buffer and restart fetching at redirect_pc
//   instr_valid/instr_ready : head handshake toward the core
//   instr, instr_pc, instr_pc_plus_4 : head word, its address, address + 4
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus_4
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

    fetch_state_e       state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic               mem_req_q, mem_req_d;

    logic               push_s;
    logic               pop_s;
    logic [CNT_W-1:0]   count_s;
    logic [CNT_W:0]     count_ext_s;
    logic [CNT_W:0]     count_after_push_s;
    logic               not_empty_s;
    fetch_entry_t       push_data_s;
    fetch_entry_t       head_s;

    assign pop_s              = not_empty_s & instr_ready;
    assign count_ext_s        = {1'b0, count_s};
    assign count_after_push_s = count_ext_s + (CNT_W + 1)'(1) - {{CNT_W{1'b0}}, pop_s};
    assign push_data_s        = '{pc: fetch_pc_q, instr: mem_rdata};

    // Fetch FSM: next state, fetch address, push strobe and request outputs.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = align_word(redirect_pc);
                    state_d    = REQ;
                end else if (count_ext_s < DEPTH_W) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (redirect) begin
                    // Returned data, if any, belongs to the abandoned path.
                    fetch_pc_d = align_word(redirect_pc);
                    state_d    = mem_ack ? REQ : DRAIN;
                end else if (mem_ack) begin
                    push_s     = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = (count_after_push_s < DEPTH_W) ? REQ : IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            DRAIN: begin
                // Old request still outstanding: keep it up, drop its data.
                if (redirect) begin
                    fetch_pc_d = align_word(redirect_pc);
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                state_d = mem_ack ? REQ : DRAIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mem_req_d = (state_d != IDLE);
        // While draining, the bus address must stay on the abandoned request.
        mem_addr_d = (state_d == DRAIN) ? mem_addr_q : fetch_pc_d;
    end

    // FSM, fetch address and registered request outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s),
        .not_empty (not_empty_s)
    );

    assign mem_req         = mem_req_q;
    assign mem_addr        = mem_addr_q;
    assign instr_valid     = not_empty_s;
    assign instr           = head_s.instr;
    assign instr_pc        = head_s.pc;
    assign instr_pc_plus_4 = not_empty_s ? (head_s.pc + 32'd4) : 32'd0;

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, instruction buffer entries (power of two, 2..16).
REQ-003 One clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 mem_req  output  1  instruction memory read request.
REQ-006 mem_addr  output  32  word-aligned fetch address.
REQ-007 mem_ack  input  1  memory accepts request and returns mem_rdata this cycle.
REQ-008 mem_rdata  input  32  fetched instruction word.
REQ-009 redirect  input  1  core-taken branch/jump/jr; flush and refetch.
REQ-010 redirect_pc  input  32  new fetch address.
REQ-011 instr_valid  output  1  buffer head holds a valid instruction.
REQ-012 instr_ready  input  1  core consumes the head this cycle.
REQ-013 instr  output  32  head instruction word.
REQ-014 instr_pc  output  32  address of the head instruction.
REQ-015 instr_pc_plus_4  output  32  instr_pc + 4, modulo 2^32.

Function
REQ-016 SHALL use FSM states IDLE, REQ, DRAIN; at most one memory request outstanding.
REQ-017 IDLE->REQ when count + 0 < DEPTH and no redirect this cycle; mem_req=1 only in REQ and DRAIN.
REQ-018 mem_addr SHALL equal fetch_pc in REQ and stay stable until mem_ack.
REQ-019 REQ with mem_ack: push {fetch_pc, mem_rdata}, fetch_pc += 4 (wraps 32'hFFFF_FFFC->0); stay REQ if count after push < DEPTH, else IDLE.
REQ-020 Zero-wait memory (mem_ack tied high) SHALL sustain one instruction per cycle.
REQ-021 Pop SHALL occur when instr_valid & instr_ready; simultaneous push and pop keeps count unchanged.
REQ-022 instr_valid = (count != 0); instr, instr_pc, instr_pc_plus_4 SHALL be 0 when empty.
REQ-023 Push-to-instr_valid latency SHALL be one cycle (registered buffer).
REQ-024 redirect SHALL take priority over push and pop: buffer flushed (count=0) next cycle, fetch_pc <= {redirect_pc[31:2], 2'b00}.
REQ-025 redirect in REQ without mem_ack -> DRAIN; mem_req held high at old address until mem_ack; returned data discarded; then REQ at new fetch_pc.
REQ-026 redirect in REQ with mem_ack same cycle -> data discarded, next state REQ at redirect address.
REQ-027 redirect in IDLE -> REQ next cycle, mem_addr = redirect address.
REQ-028 redirect in DRAIN SHALL update fetch_pc and remain DRAIN; newest redirect wins.
REQ-029 A pop in the redirect cycle SHALL be honoured by the core but has no buffer effect.

Reset
REQ-030 On rst_n low: state IDLE, fetch_pc=RESET_PC, count=0, mem_req=0, instr_valid=0, instr/instr_pc/instr_pc_plus_4=0, mem_addr=RESET_PC.
REQ-031 Reset mid-transaction SHALL abandon the request; no data captured after rst_n rises until a new request.
REQ-032 First mem_req SHALL assert on the first rising edge after rst_n deasserts.

Structure
REQ-033 Package ifetch_pkg SHALL hold state enum (IDLE, REQ, DRAIN), RESET_PC and DEPTH defaults.
REQ-034 Buffer SHALL be sub-module ifetch_fifo (64-bit entries {pc, instr}, synchronous flush, count output).
REQ-035 ifetch_unit SHALL contain FSM, fetch_pc register and request/credit logic only.

Verification
REQ-036 Reset, mem_ack=1, instr_ready=1 -> instr_pc 0,4,8,12 on consecutive cycles, mem_rdata echoed.
REQ-037 instr_ready=0, mem_ack=1 -> exactly DEPTH=4 pushes, mem_req drops, instr_pc holds 0; ready=1 resumes at address 16.
REQ-038 mem_ack delayed 3 cycles, redirect_pc=32'h0000_0100 at cycle 1 -> mem_req stays at old address until ack, data dropped, next mem_addr=32'h100, first instr_pc=32'h100.
REQ-039 redirect_pc=32'h0000_0203 -> mem_addr 32'h200; fetch_pc from 32'hFFFF_FFFC -> next address 0.
REQ-040 Redirect coincident with ack and pop at count=2 -> next cycle instr_valid=0, mem_addr=redirect address.
REQ-041 rst_n pulsed low during outstanding request -> all outputs at reset values, restart at RESET_PC.
